// File: rtl/sap_run_controller.sv
// SAP-1 run/load controller: program load, clear, free-run/single-step, halt.
// Optional retired-instruction counter is enabled by defining SAP_INSTR_COUNT_EN.
module sap_run_controller #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int RUN_DIV    = 1,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic              mode_load,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              low_halt,
  input  logic              t_end,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              low_ram_we,
  output logic              low_cpu_clr,
  output logic              cpu_en,
  output logic              load_done,
  output logic              halted,
  output logic [2:0]        state,
  output logic [7:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_RUN    = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_start_prev;
  logic                r_step_prev;
  logic                r_step_mode_q;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;
  logic                r_ram_we_n;
  logic                r_load_done;
  logic [7:0]          r_div;
  logic [3:0]          r_clr_cnt;

  logic w_start_edge;
  logic w_step_edge;
  logic w_strobe;
  logic w_accept;
  logic w_enter_load;
  logic w_mode_chg;
  logic w_en_q;
  logic w_load_ready;

  assign w_start_edge = start & ~r_start_prev;
  assign w_step_edge  = step_req & ~r_step_prev;
  assign w_strobe     = ~r_ram_we_n;
  assign w_load_ready = (r_state == S_LOAD) & r_ram_we_n;
  assign w_accept     = load_valid & w_load_ready;
  assign w_mode_chg   = step_mode ^ r_step_mode_q;
  assign w_enter_load = (w_state_next == S_LOAD) && (r_state != S_LOAD);

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // mode_load outranks every other request in every state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mode_load)         w_state_next = S_LOAD;
        else if (w_start_edge) w_state_next = S_CLEAR;
      end
      S_LOAD: begin
        if (!mode_load)        w_state_next = S_IDLE;
      end
      S_CLEAR: begin
        if (mode_load)                   w_state_next = S_LOAD;
        else if (r_clr_cnt == CLR_LAST)  w_state_next = S_RUN;
      end
      S_RUN: begin
        if (mode_load)         w_state_next = S_LOAD;
        else if (!low_halt)    w_state_next = S_HALTED;
      end
      S_HALTED: begin
        if (mode_load)         w_state_next = S_LOAD;
        else if (w_start_edge) w_state_next = S_CLEAR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_start_prev  <= 1'b0;
      r_step_prev   <= 1'b0;
      r_step_mode_q <= 1'b0;
    end else begin
      r_start_prev  <= start;
      r_step_prev   <= step_req;
      r_step_mode_q <= step_mode;
    end
  end

  // Loader write port: one-cycle strobe after each accepted word, address advances as it ends
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_we_n  <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_ram_we_n  <= ~w_accept;
      r_load_done <= w_strobe & (r_ram_addr == {ADDR_W{1'b1}});
      if (w_accept) begin
        r_ram_data <= load_data;
      end
      if (w_enter_load) begin
        r_ram_addr <= '0;
      end else if (w_strobe) begin
        r_ram_addr <= r_ram_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else begin
      r_clr_cnt <= '0;
    end
  end

  // Divider restarts whenever we are not running or the step/free-run selection flips
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_div <= '0;
    end else if ((r_state != S_RUN) || w_mode_chg || r_step_mode_q) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_en_q = r_step_mode_q ? w_step_edge : (r_div == DIV_LAST);

  // Halt and load requests gate the enable combinationally so no stray T-state slips through
  assign cpu_en      = w_en_q & low_halt & (r_state == S_RUN) & ~mode_load;
  assign low_cpu_clr = (r_state == S_RUN) || (r_state == S_HALTED);
  assign load_ready  = w_load_ready;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign low_ram_we  = r_ram_we_n;
  assign load_done   = r_load_done;
  assign halted      = (r_state == S_HALTED);
  assign state       = r_state;

`ifdef SAP_INSTR_COUNT_EN
  logic [7:0] r_instr_count;

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      r_instr_count <= 8'h00;
    end else if (r_state == S_CLEAR) begin
      r_instr_count <= 8'h00;
    end else if (cpu_en && t_end && (r_instr_count != 8'hFF)) begin
      r_instr_count <= r_instr_count + 8'h01;
    end
  end

  assign instr_count = r_instr_count;
`else
  logic w_unused_t_end;

  assign w_unused_t_end = t_end;
  assign instr_count    = 8'h00;
`endif

endmodule

// File: tb/tb_sap_run_controller.sv
// Directed bench for sap_run_controller: reset, load, clear/run/halt, step, priorities, instr_count.
`timescale 1ns/1ps
module tb_sap_run_controller;

  logic       clk;
  logic       low_clr;
  logic       mode_load;
  logic       start;
  logic       step_mode;
  logic       step_req;
  logic       low_halt;
  logic       t_end;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       low_ram_we;
  logic       low_cpu_clr;
  logic       cpu_en;
  logic       load_done;
  logic       halted;
  logic [2:0] state;
  logic [7:0] instr_count;

  int total = 0;
  int bad   = 0;

`ifdef SAP_INSTR_COUNT_EN
  localparam int CNT_SAT = 255;
`else
  localparam int CNT_SAT = 0;
`endif

  sap_run_controller #(
    .ADDR_W(4), .DATA_W(8), .RUN_DIV(1), .CLR_CYCLES(2)
  ) dut (
    .clk(clk), .low_clr(low_clr), .mode_load(mode_load), .start(start),
    .step_mode(step_mode), .step_req(step_req), .low_halt(low_halt), .t_end(t_end),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .low_ram_we(low_ram_we),
    .low_cpu_clr(low_cpu_clr), .cpu_en(cpu_en), .load_done(load_done),
    .halted(halted), .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cnt;
    low_clr = 1'b0; mode_load = 1'b0; start = 1'b0; step_mode = 1'b0;
    step_req = 1'b0; low_halt = 1'b1; t_end = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    repeat (3) cyc;
    #1;
    chk("rst_state", state, 0);
    chk("rst_cpu_clr", low_cpu_clr, 0);
    chk("rst_ram_we", low_ram_we, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", instr_count, 0);
    low_clr = 1'b1;
    cyc; #1;
    chk("idle_state", state, 0);
    chk("idle_cpu_en", cpu_en, 0);
    $display("reset released: state=%0d", state);

    // Program load of 16 words
    mode_load = 1'b1;
    cyc; #1;
    chk("load_state", state, 1);
    chk("load_addr0", ram_addr, 0);
    for (int k = 0; k < 16; k++) begin
      chk("load_ready_hi", load_ready, 1);
      chk("load_done_lo", load_done, 0);
      load_data = 8'(8'h10 + k);
      load_valid = 1'b1;
      cyc; #1;
      chk("load_we", low_ram_we, 0);
      chk("load_addr", ram_addr, k);
      chk("load_data", ram_data, 8'h10 + k);
      chk("load_ready_lo", load_ready, 0);
      $display("write addr=%0d data=%02h we=%0d", ram_addr, ram_data, low_ram_we);
      cyc; #1;
      chk("load_we_rel", low_ram_we, 1);
    end
    chk("load_done_pulse", load_done, 1);
    chk("load_wrap", ram_addr, 0);
    load_valid = 1'b0;
    mode_load  = 1'b0;
    cyc; #1;
    chk("load_exit", state, 0);
    chk("load_done_once", load_done, 0);

    // Clear then free-run
    start = 1'b1;
    cyc; #1;
    chk("clr1_state", state, 2);
    chk("clr1_low", low_cpu_clr, 0);
    chk("clr1_en", cpu_en, 0);
    start = 1'b0;
    cyc; #1;
    chk("clr2_state", state, 2);
    chk("clr2_low", low_cpu_clr, 0);
    cyc; #1;
    chk("run_state", state, 3);
    chk("run_clr_hi", low_cpu_clr, 1);
    chk("run_en", cpu_en, 1);
    en_cnt = 0;
    repeat (4) begin
      cyc; #1;
      en_cnt += int'(cpu_en);
    end
    chk("run_en_cnt", en_cnt, 4);
    $display("free run: enables=%0d", en_cnt);
    low_halt = 1'b0;
    #1;
    chk("halt_gate", cpu_en, 0);
    chk("halt_still_run", state, 3);
    cyc; #1;
    chk("halt_state", state, 4);
    chk("halt_flag", halted, 1);
    chk("halt_en", cpu_en, 0);
    chk("halt_clr_hi", low_cpu_clr, 1);
    cyc; #1;
    chk("halt_hold", state, 4);

    // Single-step: three wide pulses give three enables
    low_halt  = 1'b1;
    step_mode = 1'b1;
    cyc;
    start = 1'b1;
    cyc; #1;
    chk("step_clr", state, 2);
    start = 1'b0;
    cyc; cyc; #1;
    chk("step_run", state, 3);
    chk("step_idle_en", cpu_en, 0);
    en_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      #1;
      en_cnt += int'(cpu_en);
      repeat (4) begin
        cyc; #1;
        en_cnt += int'(cpu_en);
      end
      step_req = 1'b0;
      repeat (3) begin
        cyc; #1;
        en_cnt += int'(cpu_en);
      end
    end
    chk("step_en_cnt", en_cnt, 3);
    $display("single step: enables=%0d", en_cnt);

    // Back to free-run, then load request during RUN
    step_mode = 1'b0;
    cyc; #1;
    chk("freerun_again", cpu_en, 1);
    mode_load = 1'b1;
    #1;
    chk("run_load_gate", cpu_en, 0);
    chk("run_load_still", state, 3);
    cyc; #1;
    chk("run_to_load", state, 1);
    chk("run_load_addr", ram_addr, 0);
    chk("run_load_ready", load_ready, 1);
    mode_load = 1'b0;
    cyc; #1;
    chk("load_to_idle", state, 0);

    // mode_load beats start in IDLE; leaving LOAD mid-write still completes the strobe
    mode_load = 1'b1;
    start     = 1'b1;
    cyc; #1;
    chk("prio_idle", state, 1);
    start      = 1'b0;
    load_data  = 8'hA5;
    load_valid = 1'b1;
    mode_load  = 1'b0;
    cyc; #1;
    chk("pend_state", state, 0);
    chk("pend_we", low_ram_we, 0);
    chk("pend_data", ram_data, 8'hA5);
    chk("pend_addr", ram_addr, 0);
    load_valid = 1'b0;
    cyc; #1;
    chk("pend_done_we", low_ram_we, 1);
    chk("pend_addr_inc", ram_addr, 1);
    $display("pending strobe: addr=%0d we=%0d", ram_addr, low_ram_we);

    // 300 instructions of six T-states each
    start = 1'b1;
    cyc;
    start = 1'b0;
    cyc; cyc; #1;
    chk("cnt_run", state, 3);
    for (int i = 0; i < 1800; i++) begin
      t_end = (i % 6 == 5);
      cyc;
    end
    t_end = 1'b0;
    #1;
    chk("cnt_sat", instr_count, CNT_SAT);
    low_halt = 1'b0;
    cyc; #1;
    chk("cnt_halt_state", state, 4);
    chk("cnt_hold", instr_count, CNT_SAT);
    low_halt = 1'b1;
    start    = 1'b1;
    cyc;
    start = 1'b0;
    cyc; #1;
    chk("cnt_cleared", instr_count, 0);
    $display("instr count after restart=%0d", instr_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
